// File: rtl/mc_control_if.sv
// Handshake bundle between the instruction datapath and the multi-cycle controller.
// The master drives instruction/flag inputs; the slave (controller) drives strobes, selects and state.
interface mc_control_if;
    logic       en;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic [3:0] state;
    logic       illegal;

    modport master (
        output en, opcode, funct, zero,
        input  pc_write, pc_src, ir_write, mem_read, mem_write, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, state, illegal
    );

    modport slave (
        input  en, opcode, funct, zero,
        output pc_write, pc_src, ir_write, mem_read, mem_write, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, state, illegal
    );
endinterface

// File: rtl/mc_control.sv
// Multi-cycle MIPS-subset control FSM. Controls are registered alongside the state;
// only the en/rst strobe gating and the branch zero test are combinational.
module mc_control (
    input  logic         clk,
    input  logic         rst,
    mc_control_if.slave  bus
);
    typedef enum logic [3:0] {
        FETCH   = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2, MEMRD  = 4'd3,
        MEMWB   = 4'd4,  MEMWR  = 4'd5,  RTEXEC = 4'd6, RTWB   = 4'd7,
        BRANCH  = 4'd8,  IEXEC  = 4'd9,  IWB    = 4'd10, JUMP  = 4'd11,
        ILLEGAL = 4'd15
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_src;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic       br_ne;
    } ctl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW  = 6'b100011, OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101, OP_J   = 6'b000010, OP_JAL = 6'b000011;
    localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101, FN_SLT = 6'b101010, FN_SLL = 6'b000000;
    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3, ALU_SLT = 4'd4, ALU_SLL = 4'd5;

    state_t state_q, state_d;
    ctl_t   ctl_q;
    logic   illegal_q;

    function automatic logic funct_ok(input logic [5:0] fn);
        return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) || (fn == FN_OR) ||
               (fn == FN_SLT) || (fn == FN_SLL) || (fn == FN_JR);
    endfunction

    // Controls for a given state; opcode/funct come from the IR, stable past FETCH.
    function automatic ctl_t decode_ctl(input state_t s, input logic [5:0] op, input logic [5:0] fn);
        ctl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
                c.alu_src_b = 2'b01;
                c.alu_op    = ALU_ADD;
            end
            DECODE: c.alu_src_b = 2'b10;
            MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            MEMRD: c.mem_read = 1'b1;
            MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 2'b01;
            end
            MEMWR: c.mem_write = 1'b1;
            RTEXEC: begin
                c.alu_src_a = 1'b1;
                case (fn)
                    FN_SUB: c.alu_op = ALU_SUB;
                    FN_AND: c.alu_op = ALU_AND;
                    FN_OR:  c.alu_op = ALU_OR;
                    FN_SLT: c.alu_op = ALU_SLT;
                    FN_SLL: c.alu_op = ALU_SLL;
                    FN_JR: begin
                        c.pc_write = 1'b1;
                        c.pc_src   = 2'b11;
                    end
                    default: c.alu_op = ALU_ADD;
                endcase
            end
            RTWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 2'b01;
            end
            BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALU_SUB;
                c.pc_src    = 2'b01;
                c.br_ne     = (op == OP_BNE);
            end
            IEXEC: begin
                c.alu_src_a = 1'b1;
                if (op == OP_ORI) begin
                    c.alu_src_b = 2'b11;
                    c.alu_op    = ALU_OR;
                end else begin
                    c.alu_src_b = 2'b10;
                end
            end
            IWB: c.reg_write = 1'b1;
            JUMP: begin
                c.pc_write = 1'b1;
                c.pc_src   = 2'b10;
                if (op == OP_JAL) begin
                    c.reg_write  = 1'b1;
                    c.reg_dst    = 2'b10;
                    c.mem_to_reg = 2'b10;
                end
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW:    state_d = MEMADR;
                    OP_RTYPE:        state_d = funct_ok(bus.funct) ? RTEXEC : ILLEGAL;
                    OP_BEQ, OP_BNE:  state_d = BRANCH;
                    OP_ADDI, OP_ORI: state_d = IEXEC;
                    OP_J, OP_JAL:    state_d = JUMP;
                    default:         state_d = ILLEGAL;
                endcase
            end
            MEMADR:  state_d = (bus.opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   state_d = MEMWB;
            RTEXEC:  state_d = (bus.funct == FN_JR) ? FETCH : RTWB;
            IEXEC:   state_d = IWB;
            ILLEGAL: state_d = ILLEGAL;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FETCH;
            ctl_q     <= decode_ctl(FETCH, 6'd0, 6'd0);
            illegal_q <= 1'b0;
        end else if (bus.en) begin
            state_q   <= state_d;
            ctl_q     <= decode_ctl(state_d, bus.opcode, bus.funct);
            illegal_q <= illegal_q | (state_d == ILLEGAL);
        end
    end

    // Strobes are dropped immediately when stalled or in reset; selects pass through.
    logic strobe_en;
    assign strobe_en      = bus.en & ~rst;
    assign bus.pc_write   = strobe_en & (ctl_q.pc_write |
                            ((state_q == BRANCH) & (bus.zero ^ ctl_q.br_ne)));
    assign bus.ir_write   = strobe_en & ctl_q.ir_write;
    assign bus.mem_read   = strobe_en & ctl_q.mem_read;
    assign bus.mem_write  = strobe_en & ctl_q.mem_write;
    assign bus.reg_write  = strobe_en & ctl_q.reg_write;
    assign bus.pc_src     = ctl_q.pc_src;
    assign bus.reg_dst    = ctl_q.reg_dst;
    assign bus.mem_to_reg = ctl_q.mem_to_reg;
    assign bus.alu_src_a  = ctl_q.alu_src_a;
    assign bus.alu_src_b  = ctl_q.alu_src_b;
    assign bus.alu_op     = ctl_q.alu_op;
    assign bus.state      = state_q;
    assign bus.illegal    = illegal_q;
endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 en  input  1  advance enable; low = hold state, all write strobes forced 0.
REQ-004 opcode  input  6  current instruction [31:26] from instruction memory.
REQ-005 funct  input  6  current instruction [5:0].
REQ-006 zero  input  1  ALU zero flag, valid in BRANCH state.
REQ-007 pc_write  output  1  PC register load strobe.
REQ-008 pc_src  output  2  next PC: 00 ALU result (pc+1), 01 branch target (ALU-out register), 10 {pc[31:26],addr26}, 11 rs.
REQ-009 ir_write  output  1  instruction register load strobe.
REQ-010 mem_read, mem_write  output  1 each  data memory strobes.
REQ-011 reg_write  output  1  register file write strobe.
REQ-012 reg_dst  output  2  write address: 00 rt, 01 rd, 10 r31.
REQ-013 mem_to_reg  output  2  write data: 00 ALU-out, 01 memory data, 10 PC.
REQ-014 alu_src_a  output  1  0 PC, 1 rs.
REQ-015 alu_src_b  output  2  00 rt, 01 constant 1, 10 sign-extended imm, 11 zero-extended imm.
REQ-016 alu_op  output  4  0 add, 1 sub, 2 and, 3 or, 4 slt, 5 sll.
REQ-017 state  output  4  current state encoding.
REQ-018 illegal  output  1  sticky unsupported-instruction flag.

Function
REQ-019 Multi-cycle Moore FSM; encodings FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEXEC=6, RTWB=7, BRANCH=8, IEXEC=9, IWB=10, JUMP=11, ILLEGAL=15; all other codes return to FETCH.
REQ-020 State changes only on rising clk with en=1; en=0 holds state and forces pc_write, ir_write, mem_read, mem_write, reg_write to 0.
REQ-021 Strobes not listed for a state are 0; all selects default 0.
REQ-022 FETCH: ir_write=1, pc_write=1, pc_src=00, alu_src_a=0, alu_src_b=01, alu_op=add (word-indexed PC, increment 1); -> DECODE.
REQ-023 DECODE: alu_src_a=0, alu_src_b=10, alu_op=add (branch target precompute); next by opcode: 100011/101011 -> MEMADR; 000000 -> RTEXEC; 000100/000101 -> BRANCH; 001000/001101 -> IEXEC; 000010/000011 -> JUMP; other -> ILLEGAL.
REQ-024 R-type funct decode: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, 000000 sll, 001000 jr; other funct -> ILLEGAL from DECODE.
REQ-025 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=add; lw -> MEMRD, sw -> MEMWR.
REQ-026 MEMRD: mem_read=1 -> MEMWB. MEMWB: reg_write=1, reg_dst=00, mem_to_reg=01 -> FETCH.
REQ-027 MEMWR: mem_write=1 -> FETCH.
REQ-028 RTEXEC: alu_src_a=1, alu_src_b=00, alu_op per funct; jr instead asserts pc_write=1, pc_src=11 and -> FETCH; else -> RTWB.
REQ-029 RTWB: reg_write=1, reg_dst=01, mem_to_reg=00 -> FETCH.
REQ-030 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=sub, pc_src=01; pc_write=zero for beq, ~zero for bne (only combinational output) -> FETCH.
REQ-031 IEXEC: alu_src_a=1; addi alu_src_b=10, alu_op=add; ori alu_src_b=11, alu_op=or -> IWB. IWB: reg_write=1, reg_dst=00, mem_to_reg=00 -> FETCH.
REQ-032 JUMP: pc_write=1, pc_src=10; jal additionally reg_write=1, reg_dst=10, mem_to_reg=10 -> FETCH.
REQ-033 ILLEGAL: absorbing until reset; illegal=1; no strobes.
REQ-034 opcode/funct sampled in DECODE, MEMADR, RTEXEC, BRANCH, IEXEC, JUMP; IR holds them stable after FETCH.
REQ-035 Cycle counts: lw 5, sw 4, R-type 4, jr 3, addi/ori 4, beq/bne 3, j/jal 3.

Reset
REQ-036 rst=1 asynchronously forces state=FETCH, illegal=0; all strobes 0 while rst=1.
REQ-037 Reset mid-instruction abandons it; first edge after release performs FETCH.

Verification
REQ-038 Reset, then lw (100011), en=1 -> state sequence 0,1,2,3,4,0; mem_read=1 only in state 3; reg_write=1, mem_to_reg=01 only in 4.
REQ-039 beq with zero=1 -> state 8 asserts pc_write=1, pc_src=01; repeat zero=0 -> pc_write=0; bne inverts both.
REQ-040 R-type funct 100010 -> RTEXEC alu_op=1, RTWB reg_dst=01; funct 001000 -> pc_write=1, pc_src=11, back to FETCH after 3 cycles.
REQ-041 jal (000011) -> JUMP: pc_write=1, pc_src=10, reg_write=1, reg_dst=10, mem_to_reg=10.
REQ-042 opcode 111111 -> state 15, illegal=1 held 10 cycles; rst pulse -> state 0, illegal=0.
REQ-043 en=0 during MEMRD for 3 cycles -> state stays 3, mem_read=0; en=1 resumes to MEMWB; async rst mid-MEMADR -> state 0 before next edge.
